// File: rtl/pipe_rr_merge.sv
// Round-robin merge of NREQ producers into one single-entry pipe buffer.
// Grant is registered; the grantee enqueues one beat, then arbitration resumes.
module pipe_rr_merge #(
   parameter int width = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       enq__ENA,
   input  logic [NREQ*width-1:0] enq_v,
   output logic [NREQ-1:0]       enq__RDY,
   input  logic                  deq__ENA,
   output logic                  deq__RDY,
   output logic [width-1:0]      first,
   output logic [IDW-1:0]        first_src,
   output logic                  first__RDY,
   output logic                  proto_err
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_n;
   logic [IDW-1:0]   gnt, gnt_n;
   logic [IDW-1:0]   last, last_n;
   logic [IDW-1:0]   pick;
   logic             found;
   logic             full;
   logic [width-1:0] element;
   logic             fire;

   // Rotating search starting just after the last served producer
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(last) + k) % NREQ]) begin
            pick  = IDW'((int'(last) + k) % NREQ);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      enq__RDY = '0;
      if (state == GRANT)
         enq__RDY[gnt] = !full;
   end

   assign fire = (state == GRANT) && enq__ENA[gnt] && !full;

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      last_n  = last;
      unique case (state)
         IDLE: begin
            if (found) begin
               gnt_n   = pick;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (fire) begin
               last_n  = gnt;
               state_n = IDLE;
            end else if (!req[gnt]) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         gnt       <= '0;
         last      <= IDW'(NREQ - 1);
         full      <= 1'b0;
         element   <= '0;
         first_src <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         last  <= last_n;
         if (|(enq__ENA & ~enq__RDY))
            proto_err <= 1'b1;
         if (deq__ENA && full)
            full <= 1'b0;
         if (fire) begin
            element   <= enq_v[int'(gnt)*width +: width];
            first_src <= gnt;
            full      <= 1'b1;
         end
      end
   end

   assign deq__RDY   = full;
   assign first__RDY = full;
   assign first      = element;

endmodule
